shifter_pipe: RTL
=================

// Module: shifter_pipe
// PURPOSE
//  Pipelined, parametrised barrel shifter for the execute stage: SLL/SRL/SRA (plus optional rotates).
//  Shift is split into log2(WIDTH) binary steps spread over STAGES register slices.
//  Valid/ready handshake on both sides; flush input for branch-mispredict squash.
//  Carries a TAG (e.g. rd index) alongside each operation for writeback matching.
// PARAMETERS
//  WIDTH   32  data width; power of two, >=8
//  STAGES  2   pipeline register slices, 1..$clog2(WIDTH); latency in cycles
//  TAG_W   5   width of sideband tag carried with each operation
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  flush      in   1              squash all in-flight ops; no input accepted this cycle
//  in_valid   in   1              operation present on in_*
//  in_ready   out  1              block can accept; transfer when in_valid&&in_ready
//  in_op      in   3              000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
//  in_src     in   WIDTH          operand to shift
//  in_amt     in   $clog2(WIDTH)  shift amount (caller passes low bits only, RISC-V style)
//  in_tag     in   TAG_W          sideband, returned unchanged
//  out_valid  out  1              result present on out_*
//  out_ready  in   1              consumer accepts; transfer when out_valid&&out_ready
//  out_data   out  WIDTH          shift result
//  out_tag    out  TAG_W          tag of the op producing out_data
// BEHAVIOUR
//  - Reset: all slice valid bits 0; out_valid=0, out_data=0, out_tag=0; in_ready=1 the cycle after rst drops.
//  - Arithmetic: SLL src<<amt, zero fill. SRL logical, zero fill. SRA fills with src[WIDTH-1].
//    amt=0 returns src for every op. Ops 101..111 return 0 (still valid, tag passed).
//  - Step k (k=0..$clog2(WIDTH)-1) shifts by 2^k when amt[k]=1; steps are distributed evenly
//    over STAGES slices, with earlier slices taking the extra step. Each slice registers data,
//    remaining amt, op, tag and valid.
//  - Latency: exactly STAGES cycles from input transfer to out_valid when never stalled.
//    Throughput: 1 op/cycle.
//  - Backpressure: slice i loads when it is empty or slice i+1 loads (last slice: out_ready).
//    Bubbles collapse. in_ready = !flush && (slice0 empty || slice0 advances); combinational
//    from out_ready. Holding out_valid=1 with out_ready=0 keeps out_data/out_tag stable.
//    Ops leave in input order; none lost or duplicated.
//  - Flush: all valid bits cleared at the next edge; an in_valid in the flush cycle is not
//    accepted. out_valid may be 1 in the flush cycle. Its transfer counts only if out_ready=1;
//    otherwise that op is dropped. Data registers need not clear.
//  - rst has priority over flush. rst mid-operation discards everything in flight.
//  - Simultaneous input and output transfer on a full pipe is legal; occupancy is unchanged.
// CONFIGURATION
//  SHIFTER_PIPE_ROTATE_EN defined:
//    ROL: (src<<amt)|(src>>(WIDTH-amt)). ROR is the mirror. amt=0 returns src.
//  Not defined:
//    Ops 011/100 return 0 like other reserved codes; no rotate muxing is synthesised.
// TESTING
//  1. WIDTH=32, STAGES=2: SRA src=0x8000_00F0 amt=4 -> 0xF800_000F after 2 cycles; SRL same -> 0x0800_000F.
//  2. SLL src=0x0000_0001 amt=31 -> 0x8000_0000. Any op amt=0 src=0xDEAD_BEEF -> 0xDEAD_BEEF.
//  3. Stream 8 ops tags 0..7 with out_ready toggled 1,0,0,1...:
//     results in tag order, none lost, out_* stable while stalled, in_ready=0 only when full.
//  4. 2 ops in flight, flush=1 with in_valid=1 and out_ready=0:
//     no out_valid afterwards, flush-cycle input not accepted, next op has STAGES latency.
//  5. Assert rst with pipe full: next cycle out_valid=0, out_data=0, out_tag=0; in_ready=1 after release.
//  6. ROTATE_EN: ROL 0x8000_0001 amt=1 -> 0x0000_0003; ROR same -> 0xC000_0000. Without macro: both -> 0.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA) with valid/ready on both sides, flush and a sideband tag.
// Define SHIFTER_PIPE_ROTATE_EN to add ROL/ROR; otherwise those codes return 0 like reserved ops.
module shifter_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_src,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int BASE  = AMT_W / STAGES;
    localparam int EXTRA = AMT_W % STAGES;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // One binary step of the shifter; reserved ops arrive already zeroed, so they pass through.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] op,
                                                    input int sh);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL: r = d << sh;
            OP_SRL: r = d >> sh;
            OP_SRA: r = $signed(d) >>> sh;
`ifdef SHIFTER_PIPE_ROTATE_EN
            OP_ROL: r = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    logic             op_known;
    logic [WIDTH-1:0] in_src_masked;
    logic [STAGES-1:0] slice_valid;
    logic [STAGES-1:0] load;

    always_comb begin
        op_known = 1'b0;
        case (in_op)
            OP_SLL, OP_SRL, OP_SRA: op_known = 1'b1;
`ifdef SHIFTER_PIPE_ROTATE_EN
            OP_ROL, OP_ROR:         op_known = 1'b1;
`endif
            default:                op_known = 1'b0;
        endcase
    end

    assign in_src_masked = op_known ? in_src : '0;

    // A slice may load when it or any slice downstream of it has room, or the consumer takes the head.
    always_comb begin
        logic chain;
        load  = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain   = chain || !slice_valid[i];
            load[i] = chain;
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
            localparam int CNT   = BASE + ((gi < EXTRA) ? 1 : 0);
            localparam int START = gi * BASE + ((gi < EXTRA) ? gi : EXTRA);

            logic                   up_valid;
            logic [WIDTH-1:0]       up_data;
            logic [AMT_W-1:START]   up_amt;
            logic [2:0]             up_op;
            logic [TAG_W-1:0]       up_tag;

            logic                   valid_reg;
            logic [WIDTH-1:0]       data_reg;
            logic [AMT_W-1:START]   amt_reg;
            logic [2:0]             op_reg;
            logic [TAG_W-1:0]       tag_reg;
            logic [WIDTH-1:0]       step_data;

            if (gi == 0) begin : g_head
                assign up_valid = in_valid && !flush;
                assign up_data  = in_src_masked;
                assign up_amt   = in_amt;
                assign up_op    = in_op;
                assign up_tag   = in_tag;
            end else begin : g_body
                // Only the amount bits still to be applied travel downstream.
                assign up_valid = g_slice[gi-1].valid_reg;
                assign up_data  = g_slice[gi-1].step_data;
                assign up_amt   = g_slice[gi-1].amt_reg[AMT_W-1:START];
                assign up_op    = g_slice[gi-1].op_reg;
                assign up_tag   = g_slice[gi-1].tag_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    amt_reg   <= '0;
                    op_reg    <= '0;
                    tag_reg   <= '0;
                end else begin
                    if (flush) begin
                        valid_reg <= 1'b0;
                    end else if (load[gi]) begin
                        valid_reg <= up_valid;
                    end
                    if (load[gi] && up_valid) begin
                        data_reg <= up_data;
                        amt_reg  <= up_amt;
                        op_reg   <= up_op;
                        tag_reg  <= up_tag;
                    end
                end
            end

            // Steps run on the registered operand, so the last slice's result feeds out_data directly.
            always_comb begin
                step_data = data_reg;
                for (int k = START; k < START + CNT; k++) begin
                    if (amt_reg[k]) begin
                        step_data = shift_step(step_data, op_reg, 1 << k);
                    end
                end
            end

            assign slice_valid[gi] = valid_reg;
        end
    endgenerate

    assign in_ready  = !flush && load[0];
    assign out_valid = slice_valid[STAGES-1];
    assign out_data  = g_slice[STAGES-1].step_data;
    assign out_tag   = g_slice[STAGES-1].tag_reg;

endmodule
